// File: rtl/alu_share_arb_pkg.sv
`default_nettype none
// ============================================================================
// alu_share_arb_pkg : ALU operation encoding shared by the ALU arbiter slice
// Revision: 1.0
// ============================================================================
package alu_share_arb_pkg;

  localparam int OPW = 4;

  typedef enum logic [OPW-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } ALUop_t;

  localparam ALUop_t ALU_IDLE_OP = ALU_ADD;

endpackage
`default_nettype wire

// File: rtl/alu_share_arb_alu.sv
`default_nettype none
// ============================================================================
// alu_share_arb_alu : combinational ALU, undefined op codes give result 0
// Revision: 1.0
// ============================================================================
module alu_share_arb_alu
  import alu_share_arb_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]   srca_i,
  input  logic [W-1:0]   srcb_i,
  input  logic [OPW-1:0] op_i,
  output logic [W-1:0]   result_o,
  output logic           zero_o
);

  logic [4:0] w_shamt;
  assign w_shamt = srcb_i[4:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = srca_i + srcb_i;
      ALU_SUB:  result_o = srca_i - srcb_i;
      ALU_AND:  result_o = srca_i & srcb_i;
      ALU_OR:   result_o = srca_i | srcb_i;
      ALU_XOR:  result_o = srca_i ^ srcb_i;
      ALU_SLT:  result_o = {{(W-1){1'b0}}, ($signed(srca_i) < $signed(srcb_i))};
      ALU_SLTU: result_o = {{(W-1){1'b0}}, (srca_i < srcb_i)};
      ALU_SLL:  result_o = srca_i << w_shamt;
      ALU_SRL:  result_o = srca_i >> w_shamt;
      ALU_SRA:  result_o = $signed(srca_i) >>> w_shamt;
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule
`default_nettype wire

// File: rtl/alu_share_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// alu_share_arb_rr_pick : first requester at or after ptr, modulo N
// Revision: 1.0
// ============================================================================
module alu_share_arb_rr_pick #(
  parameter  int N  = 2,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  int best_d;
  int best_i;
  int d;

  always_comb begin
    best_d = N;
    best_i = 0;
    d      = 0;
    // Distance from the pointer decides priority; smallest distance wins.
    for (int i = 0; i < N; i++) begin
      d = (i + N - int'(ptr_i)) % N;
      if (req_i[i] && (d < best_d)) begin
        best_d = d;
        best_i = i;
      end
    end
    any_o = (best_d < N);
    idx_o = PW'(best_i);
    gnt_o = '0;
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = any_o && (i == best_i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// alu_share_arb : round-robin sharing of one ALU, single registered result slot
// Revision: 1.0
// ============================================================================
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][W-1:0]    req_srca,
  input  logic [NREQ-1:0][W-1:0]    req_srcb,
  input  logic [NREQ-1:0][OPW-1:0]  req_op,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [W-1:0]              rsp_result,
  output logic                      rsp_zero,
  output logic                      busy
);

  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    rsp_result_q, rsp_result_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NREQ-1:0] gnt_oh;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            drain;
  logic            slot_free;
  logic            grant;
  logic [W-1:0]    alu_a, alu_b, alu_res;
  logic [OPW-1:0]  alu_op;
  logic            alu_zero;

  alu_share_arb_rr_pick #(.N(NREQ)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_oh),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Only the owner's ready bit can drain the slot.
  assign drain     = |(rsp_valid_q & rsp_ready);
  assign slot_free = ~(|rsp_valid_q) | drain;
  assign grant     = slot_free & gnt_any & ~reset;
  assign req_ready = grant ? gnt_oh : '0;

  assign alu_a  = grant ? req_srca[gnt_idx] : '0;
  assign alu_b  = grant ? req_srcb[gnt_idx] : '0;
  assign alu_op = grant ? req_op[gnt_idx]   : ALU_IDLE_OP;

  alu_share_arb_alu #(.W(W)) u_alu (
    .srca_i   (alu_a),
    .srcb_i   (alu_b),
    .op_i     (alu_op),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rr_ptr_d     = rr_ptr_q;
    if (grant) begin
      rsp_valid_d  = gnt_oh;
      rsp_result_d = alu_res;
      rsp_zero_d   = alu_zero;
      rr_ptr_d     = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (drain) begin
      rsp_valid_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = |rsp_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// tb_alu_share_arb : scoreboard bench for alu_share_arb, NREQ=2 and NREQ=3
// Revision: 1.0
// ============================================================================
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  typedef struct packed {
    logic [7:0]  own;
    logic [31:0] res;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]           a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic [1:0][31:0]     a_srca, a_srcb;
  logic [1:0][OPW-1:0]  a_op;
  logic [31:0]          a_result;
  logic                 a_zero, a_busy;

  logic [2:0]           b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [2:0][31:0]     b_srca, b_srcb;
  logic [2:0][OPW-1:0]  b_op;
  logic [31:0]          b_result;
  logic                 b_zero, b_busy;

  alu_share_arb #(.NREQ(2), .W(32)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_srca(a_srca), .req_srcb(a_srcb), .req_op(a_op),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_result(a_result), .rsp_zero(a_zero), .busy(a_busy)
  );

  alu_share_arb #(.NREQ(3), .W(32)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_srca(b_srca), .req_srcb(b_srcb), .req_op(b_op),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_result(b_result), .rsp_zero(b_zero), .busy(b_busy)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input int i, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op);
    a_req_valid[i] = v;
    a_srca[i]      = a;
    a_srcb[i]      = b;
    a_op[i]        = op;
  endtask

  task automatic drv_b(input int i, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op);
    b_req_valid[i] = v;
    b_srca[i]      = a;
    b_srcb[i]      = b;
    b_op[i]        = op;
  endtask

  task automatic push_a(input logic [7:0] own, input logic [31:0] r, input logic z);
    qa.push_back('{own: own, res: r, z: z});
  endtask

  task automatic push_b(input logic [7:0] own, input logic [31:0] r, input logic z);
    qb.push_back('{own: own, res: r, z: z});
  endtask

  // Monitors: a response is compared when its owner consumes it.
  always @(negedge clk) begin
    if (!reset && (|(a_rsp_valid & a_rsp_ready))) begin
      if (qa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_unexpected_rsp: got owner %0h result %0h expected none", a_rsp_valid, a_result);
      end else begin
        ea = qa.pop_front();
        chk("a_rsp_owner",  {62'd0, a_rsp_valid}, {56'd0, ea.own});
        chk("a_rsp_result", {32'd0, a_result},    {32'd0, ea.res});
        chk("a_rsp_zero",   {63'd0, a_zero},      {63'd0, ea.z});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && (|(b_rsp_valid & b_rsp_ready))) begin
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected_rsp: got owner %0h result %0h expected none", b_rsp_valid, b_result);
      end else begin
        eb = qb.pop_front();
        chk("b_rsp_owner",  {61'd0, b_rsp_valid}, {56'd0, eb.own});
        chk("b_rsp_result", {32'd0, b_result},    {32'd0, eb.res});
        chk("b_rsp_zero",   {63'd0, b_zero},      {63'd0, eb.z});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] t4_a  [8];
  logic [31:0] t4_b  [8];
  logic [3:0]  t4_op [8];
  logic [31:0] t4_r  [8];
  logic        t4_z  [8];
  logic [1:0]  t2_own[4];

  initial begin
    reset       = 1'b1;
    a_req_valid = 2'b11;
    a_srca      = '0;
    a_srcb      = '0;
    a_op        = '0;
    a_rsp_ready = 2'b00;
    b_req_valid = 3'b111;
    b_srca      = '0;
    b_srcb      = '0;
    b_op        = '0;
    b_rsp_ready = 3'b000;

    // Reset state, grants gated while reset is high
    @(negedge clk);
    chk("rst_rsp_valid", {62'd0, a_rsp_valid}, 64'd0);
    chk("rst_result",    {32'd0, a_result},    64'd0);
    chk("rst_zero",      {63'd0, a_zero},      64'd0);
    chk("rst_busy",      {63'd0, a_busy},      64'd0);
    chk("rst_req_ready", {62'd0, a_req_ready}, 64'd0);
    chk("rst_b_ready",   {61'd0, b_req_ready}, 64'd0);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    a_req_valid = 2'b00;
    b_req_valid = 3'b000;

    // 1: ADD 5+7 on req0
    step();
    drv_a(0, 1'b1, 32'd5, 32'd7, ALU_ADD);
    a_rsp_ready = 2'b11;
    push_a(8'h01, 32'd12, 1'b0);
    @(negedge clk);
    chk("t1_req_ready", {62'd0, a_req_ready}, 64'h1);
    step();
    a_req_valid = 2'b00;
    @(negedge clk);
    chk("t1_latency", {62'd0, a_rsp_valid}, 64'h1);
    step();

    // 2: both continuously valid, pointer is 1 after test 1
    t2_own = '{2'b10, 2'b01, 2'b10, 2'b01};
    drv_a(0, 1'b1, 32'd10, 32'd1, ALU_ADD);
    drv_a(1, 1'b1, 32'hF0, 32'hFF, ALU_XOR);
    for (int k = 0; k < 4; k++) begin
      if (t2_own[k] == 2'b01) push_a(8'h01, 32'd11, 1'b0);
      else                    push_a(8'h02, 32'h0F, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_grant", {62'd0, a_req_ready}, {62'd0, t2_own[k]});
      if (k > 0) chk("t2_busy_each_cycle", {63'd0, a_busy}, 64'h1);
      step();
    end
    a_req_valid = 2'b00;
    repeat (2) step();

    // 3: held result, non-owner ready ignored, drain-and-refill
    drv_a(1, 1'b1, 32'd9, 32'd9, ALU_SUB);
    a_rsp_ready = 2'b00;
    push_a(8'h02, 32'd0, 1'b1);
    @(negedge clk);
    chk("t3_grant1", {62'd0, a_req_ready}, 64'h2);
    step();
    a_req_valid[1] = 1'b0;
    drv_a(0, 1'b1, 32'd2, 32'd3, ALU_ADD);
    a_rsp_ready = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_hold_valid",  {62'd0, a_rsp_valid}, 64'h2);
      chk("t3_hold_result", {32'd0, a_result},    64'd0);
      chk("t3_hold_zero",   {63'd0, a_zero},      64'h1);
      chk("t3_no_grant",    {62'd0, a_req_ready}, 64'd0);
      step();
    end
    a_rsp_ready = 2'b10;
    push_a(8'h01, 32'd5, 1'b0);
    @(negedge clk);
    chk("t3_refill_grant", {62'd0, a_req_ready}, 64'h1);
    step();
    a_req_valid = 2'b00;
    a_rsp_ready = 2'b11;
    repeat (2) step();

    // 4: operation table, back-to-back on req0
    t4_a  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h1,  32'h80000000, 32'hF0F0, 32'hF0F0, 32'd3};
    t4_b  = '{32'h1,        32'h1,        32'd4,        32'h25, 32'd4,        32'hFF00, 32'h0F0F, 32'd4};
    t4_op = '{ALU_SLT, ALU_SLTU, ALU_SRA, ALU_SLL, ALU_SRL, ALU_AND, ALU_OR, 4'hF};
    t4_r  = '{32'h1, 32'h0, 32'hF8000000, 32'h20, 32'h08000000, 32'hF000, 32'hFFFF, 32'h0};
    t4_z  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 8; k++) begin
      drv_a(0, 1'b1, t4_a[k], t4_b[k], t4_op[k]);
      push_a(8'h01, t4_r[k], t4_z[k]);
      @(negedge clk);
      chk("t4_grant", {62'd0, a_req_ready}, 64'h1);
      step();
    end
    a_req_valid = 2'b00;
    repeat (2) step();

    // 5: asynchronous reset with a full slot; pointer restarts at 0
    drv_a(0, 1'b1, 32'd1, 32'd1, ALU_ADD);
    a_rsp_ready = 2'b00;
    @(negedge clk);
    chk("t5_grant", {62'd0, a_req_ready}, 64'h1);
    step();
    drv_a(1, 1'b1, 32'd20, 32'd22, ALU_ADD);
    @(negedge clk);
    chk("t5_full_before_rst", {62'd0, a_rsp_valid}, 64'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_rst_valid",     {62'd0, a_rsp_valid}, 64'd0);
    chk("t5_rst_busy",      {63'd0, a_busy},      64'd0);
    chk("t5_rst_req_ready", {62'd0, a_req_ready}, 64'd0);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    a_rsp_ready = 2'b11;
    push_a(8'h01, 32'd2, 1'b0);
    @(negedge clk);
    chk("t5_first_grant", {62'd0, a_req_ready}, 64'h1);
    step();
    a_req_valid = 2'b00;
    b_req_valid = 3'b000;
    repeat (2) step();

    // 6: NREQ=3, req 1 and 2 valid, then non-owner ready ignored
    drv_b(1, 1'b1, 32'd100, 32'd1, ALU_ADD);
    drv_b(2, 1'b1, 32'd50,  32'd8, ALU_SUB);
    b_rsp_ready = 3'b110;
    push_b(8'h02, 32'd101, 1'b0);
    push_b(8'h04, 32'd42,  1'b0);
    push_b(8'h02, 32'd101, 1'b0);
    push_b(8'h04, 32'd42,  1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_grant", {61'd0, b_req_ready}, (k % 2 == 0) ? 64'h2 : 64'h4);
      step();
    end
    b_req_valid = 3'b000;
    b_rsp_ready = 3'b011;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t6_hold_valid",  {61'd0, b_rsp_valid}, 64'h4);
      chk("t6_hold_result", {32'd0, b_result},    64'd42);
      step();
    end
    b_rsp_ready = 3'b100;
    repeat (2) step();

    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
